// File: rtl/core_pause_seq.sv
// Core pause/single-step sequencer: drains the pipeline before declaring the core paused,
// and runs one-instruction steps from the paused state with a bounded drain.
module core_pause_seq #(
    parameter int DRAIN_MAX = 15
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_doPause,
    input  logic       i_stepReq,
    input  logic       i_coreIdle,
    input  logic       i_errClr,
    output logic       o_coreStall,
    output logic       o_corePaused,
    output logic       o_stepDone,
    output logic [7:0] o_stepCount,
    output logic       o_drainErr,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        DRAIN      = 3'd1,
        PAUSED     = 3'd2,
        STEP       = 3'd3,
        STEP_DRAIN = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DRAIN_MAX - 1);

    state_t     state;
    logic [7:0] drainCnt;
    logic       inDrain;
    logic       drainExit;
    logic       errSet;

    // Last budgeted cycle forces the exit even while the core is still busy.
    always_comb begin
        inDrain   = (state == DRAIN) || (state == STEP_DRAIN);
        drainExit = i_coreIdle || (drainCnt == CNT_LAST);
        errSet    = inDrain && !i_coreIdle && (drainCnt == CNT_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= RUN;
            drainCnt    <= 8'd0;
            o_stepCount <= 8'd0;
            o_drainErr  <= 1'b0;
            o_stepDone  <= 1'b0;
        end else begin
            o_stepDone <= 1'b0;
            if (errSet)
                o_drainErr <= 1'b1;
            else if (i_errClr)
                o_drainErr <= 1'b0;

            case (state)
                RUN: begin
                    if (i_doPause) begin
                        state       <= DRAIN;
                        drainCnt    <= 8'd0;
                        o_stepCount <= 8'd0;
                    end
                end
                DRAIN, STEP_DRAIN: begin
                    if (drainExit) begin
                        state <= PAUSED;
                        if (state == STEP_DRAIN) begin
                            o_stepDone  <= 1'b1;
                            o_stepCount <= o_stepCount + 8'd1;
                        end
                    end else begin
                        drainCnt <= drainCnt + 8'd1;
                    end
                end
                PAUSED: begin
                    if (!i_doPause)
                        state <= RUN;
                    else if (i_stepReq)
                        state <= STEP;
                end
                STEP: begin
                    state    <= STEP_DRAIN;
                    drainCnt <= 8'd0;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Pure state decodes: nothing here may see an input directly.
    assign o_state      = state;
    assign o_coreStall  = (state == DRAIN) || (state == PAUSED) || (state == STEP_DRAIN);
    assign o_corePaused = (state == PAUSED);

endmodule

// File: tb/tb_core_pause_seq.sv
// Bench for core_pause_seq: vector table, directed corner sequences and a random run
// compared every cycle against a behavioural model of the pause/step rules.
module tb_core_pause_seq;

    localparam int DM = 15;

    logic       i_clk = 1'b0;
    logic       i_rstn;
    logic       i_doPause, i_stepReq, i_coreIdle, i_errClr;
    logic       o_coreStall, o_corePaused, o_stepDone, o_drainErr;
    logic [7:0] o_stepCount;
    logic [2:0] o_state;

    int checks = 0;
    int errors = 0;

    core_pause_seq #(.DRAIN_MAX(DM)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_doPause(i_doPause), .i_stepReq(i_stepReq),
        .i_coreIdle(i_coreIdle), .i_errClr(i_errClr), .o_coreStall(o_coreStall),
        .o_corePaused(o_corePaused), .o_stepDone(o_stepDone), .o_stepCount(o_stepCount),
        .o_drainErr(o_drainErr), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: a drain is one mode with a flag saying whether it belongs to a step.
    typedef enum {Running, Draining, Halted, Stepping} mode_t;
    mode_t mMode;
    bit    mStepDrain;
    int    mDrainCycle;
    int    mSteps;
    bit    mErr, mDone;

    task automatic modelReset();
        mMode = Running; mStepDrain = 0; mDrainCycle = 1; mSteps = 0; mErr = 0; mDone = 0;
    endtask

    task automatic modelStep();
        bit setErr = 0;
        mDone = 0;
        case (mMode)
            Running: if (i_doPause) begin
                mMode = Draining; mStepDrain = 0; mDrainCycle = 1; mSteps = 0;
            end
            Draining: begin
                if (i_coreIdle || mDrainCycle == DM) begin
                    setErr = !i_coreIdle;
                    mMode  = Halted;
                    if (mStepDrain) begin
                        mSteps = (mSteps + 1) % 256;
                        mDone  = 1;
                    end
                end else begin
                    mDrainCycle++;
                end
            end
            Halted: begin
                if (!i_doPause) mMode = Running;
                else if (i_stepReq) mMode = Stepping;
            end
            Stepping: begin
                mMode = Draining; mStepDrain = 1; mDrainCycle = 1;
            end
            default: mMode = Running;
        endcase
        if (setErr) mErr = 1;
        else if (i_errClr) mErr = 0;
    endtask

    function automatic logic [14:0] modelVec();
        logic [2:0] st;
        case (mMode)
            Running:  st = 3'd0;
            Draining: st = mStepDrain ? 3'd4 : 3'd1;
            Halted:   st = 3'd2;
            default:  st = 3'd3;
        endcase
        return {st, 1'(mMode == Draining || mMode == Halted), 1'(mMode == Halted),
                1'(mDone), 8'(mSteps), 1'(mErr)};
    endfunction

    function automatic logic [14:0] dutVec();
        return {o_state, o_coreStall, o_corePaused, o_stepDone, o_stepCount, o_drainErr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic setIn(input logic dp, input logic sr, input logic idle, input logic clr);
        i_doPause = dp; i_stepReq = sr; i_coreIdle = idle; i_errClr = clr;
    endtask

    // One clock: the model consumes the same inputs the DUT samples, outputs compared mid-cycle.
    task automatic tick(input string name);
        @(posedge i_clk);
        if (i_rstn) modelStep();
        @(negedge i_clk);
        chk(name, dutVec(), modelVec());
    endtask

    // Asynchronous reset pulse between edges; outputs must react without a clock.
    task automatic pulseReset(input string name);
        i_rstn = 1'b0;
        #1;
        modelReset();
        chk(name, dutVec(), 15'd0);
        #1;
        i_rstn = 1'b1;
    endtask

    typedef struct {
        logic dp, sr, idle, clr;
        logic [2:0] st;
        logic stall, paused, done;
        logic [7:0] cnt;
        logic err;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic dp, input logic sr, input logic idle, input logic clr,
                                input logic [2:0] st, input logic stall, input logic paused,
                                input logic done, input logic [7:0] cnt, input logic err);
        vec_t v;
        v.dp = dp; v.sr = sr; v.idle = idle; v.clr = clr; v.st = st; v.stall = stall;
        v.paused = paused; v.done = done; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    initial begin
        int n;
        //              dp sr id cl  st stl pau dn cnt err
        tbl[0]  = mk(1, 0, 0, 0, 3'd1, 1, 0, 0, 8'd0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 3'd1, 1, 0, 0, 8'd0, 0);
        tbl[2]  = mk(1, 0, 1, 0, 3'd2, 1, 1, 0, 8'd0, 0);
        tbl[3]  = mk(1, 1, 1, 0, 3'd3, 0, 0, 0, 8'd0, 0);
        tbl[4]  = mk(1, 1, 1, 0, 3'd4, 1, 0, 0, 8'd0, 0);
        tbl[5]  = mk(1, 1, 1, 0, 3'd2, 1, 1, 1, 8'd1, 0);
        tbl[6]  = mk(1, 1, 1, 0, 3'd3, 0, 0, 0, 8'd1, 0);
        tbl[7]  = mk(1, 1, 1, 0, 3'd4, 1, 0, 0, 8'd1, 0);
        tbl[8]  = mk(1, 1, 1, 0, 3'd2, 1, 1, 1, 8'd2, 0);
        tbl[9]  = mk(1, 1, 1, 0, 3'd3, 0, 0, 0, 8'd2, 0);
        tbl[10] = mk(1, 1, 1, 0, 3'd4, 1, 0, 0, 8'd2, 0);
        tbl[11] = mk(1, 1, 1, 0, 3'd2, 1, 1, 1, 8'd3, 0);
        tbl[12] = mk(1, 0, 1, 0, 3'd2, 1, 1, 0, 8'd3, 0);
        tbl[13] = mk(0, 1, 1, 0, 3'd0, 0, 0, 0, 8'd3, 0);
        tbl[14] = mk(0, 0, 0, 1, 3'd0, 0, 0, 0, 8'd3, 0);
        tbl[15] = mk(1, 0, 0, 0, 3'd1, 1, 0, 0, 8'd0, 0);
        tbl[16] = mk(0, 0, 1, 0, 3'd2, 1, 1, 0, 8'd0, 0);
        tbl[17] = mk(0, 0, 1, 0, 3'd0, 0, 0, 0, 8'd0, 0);

        i_rstn = 1'b0;
        setIn(1, 1, 0, 0);
        modelReset();
        repeat (2) @(negedge i_clk);
        chk("resetState", dutVec(), 15'd0);
        setIn(0, 0, 0, 0);
        i_rstn = 1'b1;

        // Pause with idle on the 2nd drain cycle, three held steps, release, re-pause.
        for (int i = 0; i < 18; i++) begin
            setIn(tbl[i].dp, tbl[i].sr, tbl[i].idle, tbl[i].clr);
            @(posedge i_clk);
            modelStep();
            @(negedge i_clk);
            chk($sformatf("table[%0d]", i), dutVec(),
                {tbl[i].st, tbl[i].stall, tbl[i].paused, tbl[i].done, tbl[i].cnt, tbl[i].err});
        end

        // Drain timeout: busy core for the whole budget.
        setIn(1, 0, 0, 0);
        tick("toEnter");
        n = 0;
        while (o_state == 3'd1 && n < 40) begin
            n++;
            tick("toDrain");
        end
        chk("drainCycles", n, DM);
        chk("timeoutErr", {o_state, o_corePaused, o_drainErr}, {3'd2, 1'b1, 1'b1});

        setIn(1, 0, 0, 1);
        tick("errClear");
        chk("errCleared", o_drainErr, 0);

        // Step whose drain also times out while the clear is held: set wins.
        setIn(1, 1, 0, 1);
        tick("stepTo1");
        setIn(1, 0, 0, 1);
        n = 0;
        tick("stepTo2");
        while (o_state == 3'd4 && n < 40) begin
            n++;
            tick("stepToDrain");
        end
        chk("stepTimeout", {o_state, o_stepDone, o_stepCount, o_drainErr},
            {3'd2, 1'b1, 8'd1, 1'b1});

        // Step counter wrap from 255.
        setIn(1, 1, 1, 0);
        n = 0;
        while (o_stepCount != 8'd255 && n < 1000) begin
            n++;
            tick("wrapRun");
        end
        chk("wrapReach", o_stepCount, 255);
        repeat (3) tick("wrapLast");
        chk("wrapZero", {o_stepCount, o_stepDone}, {8'd0, 1'b1});

        // Reset in the middle of a step drain abandons it.
        setIn(1, 1, 0, 0);
        tick("rstStep");
        tick("rstStepDrain");
        tick("rstStepDrain2");
        chk("inStepDrain", o_state, 3'd4);
        pulseReset("rstMidStep");
        setIn(1, 0, 1, 0);
        tick("rstReenter");
        chk("reenterDrain", {o_state, o_stepDone}, {3'd1, 1'b0});
        tick("rstPause");
        chk("noStepDone", {o_state, o_stepDone}, {3'd2, 1'b0});

        // Randomized traffic, pause mostly held so steps and timeouts happen often.
        for (int i = 0; i < 3000; i++) begin
            setIn(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0));
            tick("random");
            if ($urandom_range(0, 199) == 0) pulseReset("randomReset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_pause_seq.md
CORE_PAUSE_SEQ -- requirements
Module: core_pause_seq

Interface
REQ-001 Parameter DRAIN_MAX, default 15, sets the maximum cycles spent draining before a forced pause; the legal range is 1..255.
REQ-002 i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 i_rstn  in  1  reset, asynchronous and active-low.
REQ-004 i_doPause  in  1  pause request; level, from the core control register (write-set or halt-set).
REQ-005 i_stepReq  in  1  single-step request; level sampled only while PAUSED.
REQ-006 i_coreIdle  in  1  core pipeline has no instruction in flight.
REQ-007 i_errClr  in  1  clears the sticky drain-timeout flag.
REQ-008 o_coreStall  out  1  freezes core fetch when high.
REQ-009 o_corePaused  out  1  the core is fully paused and safe to inspect.
REQ-010 o_stepDone  out  1  one-cycle pulse when a single step completes.
REQ-011 o_stepCount  out  8  count of completed single steps.
REQ-012 o_drainErr  out  1  sticky flag: a drain timed out.
REQ-013 o_state  out  3  state readout for debug mapping: RUN=0, DRAIN=1, PAUSED=2, STEP=3, STEP_DRAIN=4.

Function
REQ-014 The block SHALL implement a Moore FSM with the states RUN, DRAIN, PAUSED, STEP and STEP_DRAIN; encodings 5-7 SHALL recover to RUN on the next edge.
REQ-015 RUN: if i_doPause=1 at edge N, the state SHALL be DRAIN at N+1, the drain counter SHALL be 0 and o_stepCount SHALL clear to 0; otherwise the FSM stays in RUN.
REQ-016 DRAIN and STEP_DRAIN: the drain counter SHALL start at 0 on entry and increment on each cycle in which i_coreIdle=0.
REQ-017 DRAIN and STEP_DRAIN, idle exit: i_coreIdle=1 SHALL move the FSM to PAUSED on the next edge, including when i_coreIdle=1 on the first drain cycle.
REQ-018 DRAIN and STEP_DRAIN, timeout exit: if i_coreIdle=0 while the counter equals DRAIN_MAX-1, the FSM SHALL move to PAUSED and set o_drainErr, so at most DRAIN_MAX cycles are spent draining.
REQ-019 DRAIN and STEP_DRAIN SHALL ignore i_doPause deassertion; a drain always completes to PAUSED.
REQ-020 PAUSED: i_doPause=0 SHALL move the FSM to RUN.
REQ-021 PAUSED: if i_doPause=1 and i_stepReq=1, the FSM SHALL move to STEP; release (i_doPause=0) takes priority over i_stepReq.
REQ-022 STEP SHALL last exactly one cycle, then move unconditionally to STEP_DRAIN.
REQ-023 On a STEP_DRAIN->PAUSED transition, o_stepDone SHALL be high for exactly the first PAUSED cycle, and o_stepCount SHALL increment with wrap from 255 to 0.
REQ-024 On a STEP_DRAIN->PAUSED transition by timeout, o_stepDone and the count increment SHALL still occur, and o_drainErr SHALL also set.
REQ-025 i_stepReq outside PAUSED SHALL be ignored and not queued; a level held high SHALL produce one step per PAUSED visit, i.e. one step every 3+ cycles.
REQ-026 o_coreStall SHALL be 0 in RUN and STEP, and 1 in DRAIN, PAUSED and STEP_DRAIN.
REQ-027 o_corePaused SHALL be 1 only in PAUSED.
REQ-028 o_coreStall, o_corePaused and o_state SHALL be decoded from the state register only, with no combinational path from any input.
REQ-029 o_drainErr SHALL clear on i_errClr=1; if a set and a clear occur in the same cycle, the set SHALL win.

Reset
REQ-030 i_rstn=0 SHALL asynchronously force state=RUN, drain counter=0, o_stepCount=0, o_drainErr=0 and o_stepDone=0.
REQ-031 Consequently, reset SHALL drive o_coreStall=0 and o_corePaused=0.
REQ-032 Reset asserted mid-drain or mid-step SHALL abandon the operation with no o_stepDone pulse; after release the FSM starts in RUN and re-enters DRAIN one edge later if i_doPause is still 1.

Verification
REQ-033 i_doPause 0->1, i_coreIdle=1 at the 2nd DRAIN cycle -> o_coreStall=1 at N+1, o_corePaused=1 at N+3, o_drainErr=0.
REQ-034 DRAIN_MAX=15, i_coreIdle held 0 -> exactly 15 DRAIN cycles, then PAUSED with o_drainErr=1; i_errClr together with a new timeout -> o_drainErr stays 1.
REQ-035 From PAUSED, i_stepReq held 1 for 3 steps with i_coreIdle=1 -> o_coreStall=0 for one cycle per step, three o_stepDone pulses, o_stepCount=3.
REQ-036 o_stepCount=255 followed by one completed step -> o_stepCount=0 and o_stepDone=1.
REQ-037 PAUSED with i_doPause=0 and i_stepReq=1 on the same cycle -> RUN (o_state=0), o_stepCount unchanged; a later re-pause -> o_stepCount=0.
REQ-038 i_rstn pulsed low during STEP_DRAIN -> o_state=0, o_coreStall=0 immediately, no o_stepDone pulse.
